serial_addsub: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/serial_digit_adder.sv | 30 +++
 rtl/serial_addsub.sv | 148 ++++++++++++++
 tb/tb_serial_addsub.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
package serial_arith_pkg;

    // Control states of the serial add/sub sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n_digits inclusive
    function automatic int unsigned cnt_width(input int unsigned n_digits);
        return $clog2(n_digits + 1);
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its top bit.
module serial_digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    // Ripple the carry through the digit, capturing the carry entering the top bit
    always_comb begin
        logic c;
        s        = '0;
        co       = 1'b0;
        c_msb_in = 1'b0;
        c        = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) begin
                c_msb_in = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: parallel load, LSB-first processing, serial and word result.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [DIGIT-1:0] sout,
    output logic             sout_valid
);

    // Reject parameterisations the datapath cannot support
    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = cnt_width(NDIG);

    state_t           r_state;
    state_t           w_next;
    logic             w_run;
    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [DIGIT-1:0] r_sout;
    logic             r_sout_valid;

    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_res_next;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x        (r_a[DIGIT-1:0]),
        .y        (r_b[DIGIT-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb_in)
    );

    // New digit enters at the top of the result register as it shifts right
    assign w_res_next = WIDTH'({w_s, r_res} >> DIGIT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State decodes: handshake flags and datapath enables
    always_comb begin
        w_run    = (r_state == ST_RUN);
        w_busy   = w_run;
        w_done   = (r_state == ST_DONE);
        w_accept = start && !w_run;
        w_last   = w_run && (r_cnt == CW'(NDIG - 1));
    end

    // Operand load, per-digit shifting and final result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_carry      <= 1'b0;
            r_res        <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_ovf        <= 1'b0;
            r_sout       <= '0;
            r_sout_valid <= 1'b0;
        end else if (w_accept) begin
            r_a          <= a;
            r_b          <= sub ? ~b : b;
            r_carry      <= cin ^ sub;
            r_res        <= '0;
            r_cnt        <= '0;
            r_sout       <= '0;
            r_sout_valid <= 1'b0;
        end else if (w_run) begin
            r_a          <= r_a >> DIGIT;
            r_b          <= r_b >> DIGIT;
            r_carry      <= w_co;
            r_res        <= w_res_next;
            r_cnt        <= r_cnt + CW'(1);
            r_sout       <= w_s;
            r_sout_valid <= 1'b1;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_co;
                r_ovf  <= w_c_msb_in ^ w_co;
            end
        end else begin
            r_sout_valid <= 1'b0;
        end
    end

    assign busy       = w_busy;
    assign done       = w_done;
    assign sum        = r_sum;
    assign cout       = r_cout;
    assign ovf        = r_ovf;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: one DIGIT=1 and one DIGIT=4 instance.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start1, sub1, cin1;
    logic [7:0] a1, b1;
    logic       busy1, done1, cout1, ovf1, sv1;
    logic [7:0] sum1;
    logic [0:0] sout1;

    logic       start4, sub4, cin4;
    logic [7:0] a4, b4;
    logic       busy4, done4, cout4, ovf4, sv4;
    logic [7:0] sum4;
    logic [3:0] sout4;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .sub(sub1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
        .sout(sout1), .sout_valid(sv1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .sub(sub4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
        .sout(sout4), .sout_valid(sv4)
    );

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       q_res1[$];
    exp_t       q_res4[$];
    logic [3:0] q_dig1[$];
    logic [3:0] q_dig4[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Push the expected word result and the LSB-first digit stream
    task automatic expect_op(input int sel, input logic [7:0] s, input logic co,
                             input logic ov, input bit push_res);
        exp_t e;
        e.sum  = s;
        e.cout = co;
        e.ovf  = ov;
        if (sel == 1) begin
            if (push_res) q_res1.push_back(e);
            for (int i = 0; i < 8; i++) q_dig1.push_back(4'(s[i]));
        end else begin
            if (push_res) q_res4.push_back(e);
            for (int i = 0; i < 2; i++) q_dig4.push_back(s[i*4 +: 4]);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic sb, input logic ci);
        if (sel == 1) begin
            start1 = st; a1 = av; b1 = bv; sub1 = sb; cin1 = ci;
        end else begin
            start4 = st; a4 = av; b4 = bv; sub4 = sb; cin4 = ci;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : done4;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : busy4;
    endfunction

    // One-cycle start pulse; returns 1 time unit after the accepting edge
    task automatic issue(input int sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic sb, input logic ci);
        @(posedge clk); #1;
        drive(sel, 1'b1, av, bv, sb, ci);
        @(posedge clk); #1;
        drive(sel, 1'b0, av, bv, sb, ci);
    endtask

    // Wait for done with a cycle budget, measuring latency and busy cycles
    task automatic wait_done(input int sel, input int exp_lat, input int exp_busy,
                             input int pulse_at);
        int k  = 0;
        int bc = 0;
        while (!get_done(sel) && k < 40) begin
            if (get_busy(sel)) bc++;
            if (k == pulse_at)     drive(sel, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
            if (k == pulse_at + 1) drive(sel, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
            @(posedge clk); #1;
            k++;
        end
        drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("done_seen", 32'(get_done(sel)), 32'd1);
        check("latency", 32'(k), 32'(exp_lat));
        check("busy_cycles", 32'(bc), 32'(exp_busy));
    endtask

    // Monitor: compare serial digits and word results as the DUTs present them
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sv1) begin
                if (q_dig1.size() == 0) check("d1_sout_unexpected", 32'd1, 32'd0);
                else check("d1_sout", 32'(sout1), 32'(q_dig1.pop_front()));
            end
            if (done1) begin
                check("d1_last_digit_with_done", 32'(sv1), 32'd1);
                if (q_res1.size() == 0) check("d1_done_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_res1.pop_front();
                    check("d1_sum", 32'(sum1), 32'(e.sum));
                    check("d1_cout", 32'(cout1), 32'(e.cout));
                    check("d1_ovf", 32'(ovf1), 32'(e.ovf));
                end
            end
            if (sv4) begin
                if (q_dig4.size() == 0) check("d4_sout_unexpected", 32'd1, 32'd0);
                else check("d4_sout", 32'(sout4), 32'(q_dig4.pop_front()));
            end
            if (done4) begin
                check("d4_last_digit_with_done", 32'(sv4), 32'd1);
                if (q_res4.size() == 0) check("d4_done_unexpected", 32'd1, 32'd0);
                else begin
                    e = q_res4.pop_front();
                    check("d4_sum", 32'(sum4), 32'(e.sum));
                    check("d4_cout", 32'(cout4), 32'(e.cout));
                    check("d4_ovf", 32'(ovf4), 32'(e.ovf));
                end
            end
        end
    end

    task automatic check_d1_zero(input string tag);
        check({tag, "_busy"}, 32'(busy1), 32'd0);
        check({tag, "_done"}, 32'(done1), 32'd0);
        check({tag, "_sum"},  32'(sum1),  32'd0);
        check({tag, "_cout"}, 32'(cout1), 32'd0);
        check({tag, "_ovf"},  32'(ovf1),  32'd0);
        check({tag, "_sout"}, 32'(sout1), 32'd0);
        check({tag, "_sv"},   32'(sv1),   32'd0);
    endtask

    initial begin : stimulus
        int nd;
        reset = 1'b1;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        check_d1_zero("rst");
        check("rst_d4_sum", 32'(sum4), 32'd0);
        check("rst_d4_busy", 32'(busy4), 32'd0);
        #20;
        @(negedge clk);
        reset = 1'b0;

        // 0x5A + 0x33 + 1
        expect_op(1, 8'h8E, 1'b0, 1'b1, 1'b1);
        issue(1, 8'h5A, 8'h33, 1'b0, 1'b1);
        wait_done(1, 8, 8, -1);

        // 0x10 - 0x20, then 0x80 - 0x01
        expect_op(1, 8'hF0, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h10, 8'h20, 1'b1, 1'b0);
        wait_done(1, 8, 8, -1);
        expect_op(1, 8'h7F, 1'b1, 1'b1, 1'b1);
        issue(1, 8'h80, 8'h01, 1'b1, 1'b0);
        wait_done(1, 8, 8, -1);

        // DIGIT=4: 0xFF + 0x01, then 0x7F + 0x01
        expect_op(4, 8'h00, 1'b1, 1'b0, 1'b1);
        issue(4, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(4, 2, 2, -1);
        expect_op(4, 8'h80, 1'b0, 1'b1, 1'b1);
        issue(4, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(4, 2, 2, -1);

        // start pulsed mid-RUN with other operands is ignored
        expect_op(1, 8'h46, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(1, 8, 8, 2);

        // Back-to-back: start held through DONE
        expect_op(1, 8'h2C, 1'b1, 1'b0, 1'b1);
        expect_op(1, 8'hFB, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b1, 8'hC8, 8'h64, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b1, 8'h05, 8'h09, 1'b1, 1'b1);
        nd = 0;
        do begin
            @(posedge clk); #1;
            nd++;
        end while (!done1 && nd < 40);
        check("b2b_first_latency", 32'(nd), 32'd8);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h05, 8'h09, 1'b1, 1'b1);
        check("b2b_no_idle_busy", 32'(busy1), 32'd1);
        check("b2b_done_dropped", 32'(done1), 32'd0);
        wait_done(1, 8, 8, -1);

        // Asynchronous reset mid-operation aborts without a done
        expect_op(1, 8'h03, 1'b0, 1'b0, 1'b0);
        issue(1, 8'h01, 8'h02, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_d1_zero("abort");
        q_dig1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done1) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        check("abort_sum_cleared", 32'(sum1), 32'd0);

        // Fresh operation after the abort
        expect_op(1, 8'h80, 1'b0, 1'b1, 1'b1);
        issue(1, 8'h40, 8'h40, 1'b0, 1'b0);
        wait_done(1, 8, 8, -1);

        repeat (3) @(posedge clk);
        #1;
        check("drain_res1", 32'(q_res1.size()), 32'd0);
        check("drain_res4", 32'(q_res4.size()), 32'd0);
        check("drain_dig1", 32'(q_dig1.size()), 32'd0);
        check("drain_dig4", 32'(q_dig4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
